// File: rtl/p2m_echo_request_deser.sv
// Pipe-to-method deserializer for EchoRequest: reassembles header+payload words from the host
// pipe and invokes say/say2 through a ready/enable handshake; malformed messages are drained.
module p2m_echo_request_deser #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned ERR_W  = 8
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              pipe_enq_ena,
    input  logic [WORD_W-1:0] pipe_enq_v,
    output logic              pipe_enq_rdy,
    output logic              say_ena,
    output logic [31:0]       say_v,
    input  logic              say_rdy,
    output logic              say2_ena,
    output logic [31:0]       say2_a,
    output logic [31:0]       say2_b,
    input  logic              say2_rdy,
    output logic [ERR_W-1:0]  err_count,
    output logic              busy
);

    typedef enum logic [1:0] {
        StHdr,
        StPayload,
        StDispatch,
        StDrain
    } state_e;

    state_e           state_q, state_d;
    logic             is_say2_q, is_say2_d;
    logic [15:0]      len_q, len_d;
    logic [15:0]      rem_q, rem_d;
    logic [31:0]      say_v_q, say_v_d;
    logic [31:0]      say2_a_q, say2_a_d;
    logic [31:0]      say2_b_q, say2_b_d;
    logic [ERR_W-1:0] err_q, err_d;

    logic        accept;
    logic [15:0] hdr_id;
    logic [15:0] hdr_len;
    logic        hdr_valid;
    logic [15:0] rem_dec;
    logic [15:0] slot;
    logic        fire;

    assign accept    = pipe_enq_ena && pipe_enq_rdy;
    assign hdr_id    = pipe_enq_v[31:16];
    assign hdr_len   = pipe_enq_v[15:0];
    assign hdr_valid = ((hdr_id == 16'd0) && (hdr_len == 16'd2)) ||
                       ((hdr_id == 16'd1) && (hdr_len == 16'd3));
    assign rem_dec   = rem_q - 16'd1;
    // Argument slot index counts up from 0 as remaining counts down.
    assign slot      = len_q - 16'd1 - rem_q;
    assign fire      = (state_q == StDispatch) && (is_say2_q ? say2_rdy : say_rdy);

    always_comb begin
        state_d   = state_q;
        is_say2_d = is_say2_q;
        len_d     = len_q;
        rem_d     = rem_q;
        say_v_d   = say_v_q;
        say2_a_d  = say2_a_q;
        say2_b_d  = say2_b_q;
        err_d     = err_q;

        unique case (state_q)
            StHdr: begin
                if (accept) begin
                    is_say2_d = hdr_id[0];
                    len_d     = hdr_len;
                    rem_d     = hdr_len - 16'd1;
                    if (hdr_valid) begin
                        state_d = StPayload;
                    end else begin
                        if (err_q != {ERR_W{1'b1}}) begin
                            err_d = err_q + 1'b1;
                        end
                        // len of 0 or 1 means the header was the whole message.
                        state_d = (hdr_len <= 16'd1) ? StHdr : StDrain;
                    end
                end
            end
            StPayload: begin
                if (accept) begin
                    if (slot == 16'd0) begin
                        if (is_say2_q) begin
                            say2_a_d = pipe_enq_v[31:0];
                        end else begin
                            say_v_d = pipe_enq_v[31:0];
                        end
                    end else if (slot == 16'd1) begin
                        say2_b_d = pipe_enq_v[31:0];
                    end
                    rem_d = rem_dec;
                    if (rem_dec == 16'd0) begin
                        state_d = StDispatch;
                    end
                end
            end
            StDispatch: begin
                if (fire) begin
                    state_d = StHdr;
                end
            end
            StDrain: begin
                if (accept) begin
                    rem_d = rem_dec;
                    if (rem_dec == 16'd0) begin
                        state_d = StHdr;
                    end
                end
            end
            default: state_d = StHdr;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= StHdr;
            is_say2_q <= 1'b0;
            len_q     <= 16'd0;
            rem_q     <= 16'd0;
            say_v_q   <= 32'd0;
            say2_a_q  <= 32'd0;
            say2_b_q  <= 32'd0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            is_say2_q <= is_say2_d;
            len_q     <= len_d;
            rem_q     <= rem_d;
            say_v_q   <= say_v_d;
            say2_a_q  <= say2_a_d;
            say2_b_q  <= say2_b_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        pipe_enq_rdy = (state_q != StDispatch);
        busy         = (state_q != StHdr);
        say_ena      = fire && !is_say2_q;
        say2_ena     = fire && is_say2_q;
        say_v        = say_v_q;
        say2_a       = say2_a_q;
        say2_b       = say2_b_q;
        err_count    = err_q;
    end

endmodule

// File: tb/tb_p2m_echo_request_deser.sv
// Directed bench for p2m_echo_request_deser; expected method calls go through a scoreboard queue.
module tb_p2m_echo_request_deser;

    logic        CLK;
    logic        nRST;
    logic        pipe_enq_ena;
    logic [31:0] pipe_enq_v;
    logic        pipe_enq_rdy;
    logic        say_ena;
    logic [31:0] say_v;
    logic        say_rdy;
    logic        say2_ena;
    logic [31:0] say2_a;
    logic [31:0] say2_b;
    logic        say2_rdy;
    logic [7:0]  err_count;
    logic        busy;

    typedef struct {
        bit          is2;
        logic [31:0] a;
        logic [31:0] b;
    } call_t;

    call_t exp_q[$];
    int    n_cmp  = 0;
    int    n_err  = 0;
    int    n_fire = 0;

    p2m_echo_request_deser #(.WORD_W(32), .ERR_W(8)) dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .pipe_enq_ena (pipe_enq_ena),
        .pipe_enq_v   (pipe_enq_v),
        .pipe_enq_rdy (pipe_enq_rdy),
        .say_ena      (say_ena),
        .say_v        (say_v),
        .say_rdy      (say_rdy),
        .say2_ena     (say2_ena),
        .say2_a       (say2_a),
        .say2_b       (say2_b),
        .say2_rdy     (say2_rdy),
        .err_count    (err_count),
        .busy         (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] w);
        int t = 0;
        @(negedge CLK);
        while (!pipe_enq_rdy && t < 100) begin
            @(negedge CLK);
            t++;
        end
        if (t >= 100) check("rdy_timeout", 32'(t), 32'd0);
        pipe_enq_ena = 1'b1;
        pipe_enq_v   = w;
        @(posedge CLK);
        #1 pipe_enq_ena = 1'b0;
    endtask

    task automatic send_say(input logic [31:0] v);
        call_t c;
        c.is2 = 1'b0; c.a = v; c.b = 32'd0;
        exp_q.push_back(c);
        send(32'h0000_0002);
        send(v);
    endtask

    task automatic send_say2(input logic [31:0] a, input logic [31:0] b);
        call_t c;
        c.is2 = 1'b1; c.a = a; c.b = b;
        exp_q.push_back(c);
        send(32'h0001_0003);
        send(a);
        send(b);
    endtask

    task automatic drain_wait();
        int t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(negedge CLK);
            t++;
        end
        @(negedge CLK);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // Scoreboard: every enable is matched against the oldest expected call.
    always @(negedge CLK) begin
        if (nRST) begin
            if (say_ena && say2_ena) check("both_ena", 32'd1, 32'd0);
            if (say_ena || say2_ena) begin
                n_fire++;
                check("fire_rdy_low", 32'(pipe_enq_rdy), 32'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_fire", 32'(exp_q.size()), 32'd1);
                end else begin
                    call_t c;
                    c = exp_q.pop_front();
                    check("fire_kind", 32'(say2_ena), 32'(c.is2));
                    if (c.is2) begin
                        check("say2_a", say2_a, c.a);
                        check("say2_b", say2_b, c.b);
                    end else begin
                        check("say_v", say_v, c.a);
                    end
                end
            end
        end
    end

    initial begin
        int f0;
        nRST         = 1'b0;
        pipe_enq_ena = 1'b0;
        pipe_enq_v   = 32'd0;
        say_rdy      = 1'b1;
        say2_rdy     = 1'b1;
        #3;
        check("rst_rdy", 32'(pipe_enq_rdy), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_say_ena", 32'(say_ena), 32'd0);
        check("rst_say2_ena", 32'(say2_ena), 32'd0);
        check("rst_say_v", say_v, 32'd0);
        check("rst_say2_a", say2_a, 32'd0);
        check("rst_say2_b", say2_b, 32'd0);
        check("rst_err", 32'(err_count), 32'd0);
        @(negedge CLK);
        nRST = 1'b1;

        // say: enable one cycle after the payload word, exactly one cycle long
        send_say(32'hDEAD_BEEF);
        @(negedge CLK);
        check("say_fire", 32'(say_ena), 32'd1);
        check("say_fire_v", say_v, 32'hDEAD_BEEF);
        check("say_fire_rdy", 32'(pipe_enq_rdy), 32'd0);
        @(negedge CLK);
        check("say_one_cycle", 32'(say_ena), 32'd0);
        check("say_back_idle", 32'(busy), 32'd0);

        // say2 with 5 stalled cycles
        say2_rdy = 1'b0;
        f0 = n_fire;
        send_say2(32'h1111_1111, 32'h2222_2222);
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            check("stall_ena", 32'(say2_ena), 32'd0);
            check("stall_rdy", 32'(pipe_enq_rdy), 32'd0);
            check("stall_busy", 32'(busy), 32'd1);
        end
        @(posedge CLK);
        #1 say2_rdy = 1'b1;
        @(negedge CLK);
        check("say2_fire", 32'(say2_ena), 32'd1);
        @(negedge CLK);
        check("say2_single", 32'(n_fire - f0), 32'd1);
        check("say2_after_rdy", 32'(pipe_enq_rdy), 32'd1);
        send_say(32'h0BAD_F00D);
        drain_wait();

        // unknown id drained and counted
        f0 = n_fire;
        send(32'h0007_0004);
        send(32'hAAAA_AAAA);
        send(32'h0000_0002);
        send(32'h0001_0003);
        @(negedge CLK);
        check("unk_err", 32'(err_count), 32'd1);
        check("unk_idle", 32'(busy), 32'd0);
        check("unk_no_fire", 32'(n_fire - f0), 32'd0);
        send_say(32'h1234_5678);
        drain_wait();

        // bad lengths
        @(negedge CLK);
        nRST = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;
        send(32'h0000_0001);
        @(negedge CLK);
        check("len1_err", 32'(err_count), 32'd1);
        check("len1_hdr", 32'(busy), 32'd0);
        send(32'h0000_0000);
        @(negedge CLK);
        check("len0_err", 32'(err_count), 32'd2);
        check("len0_hdr", 32'(busy), 32'd0);
        send_say(32'hCAFE_F00D);
        drain_wait();

        // asynchronous reset mid-message
        f0 = n_fire;
        send(32'h0001_0003);
        send(32'h5555_5555);
        #2 nRST = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_rdy", 32'(pipe_enq_rdy), 32'd1);
        check("arst_err", 32'(err_count), 32'd0);
        check("arst_ena", 32'(say2_ena), 32'd0);
        @(negedge CLK);
        nRST = 1'b1;
        send_say(32'h0F0F_0F0F);
        drain_wait();
        check("arst_fires", 32'(n_fire - f0), 32'd1);

        // saturation, then back-to-back says
        for (int i = 0; i < 260; i++) send(32'h00FF_0001);
        @(negedge CLK);
        check("sat_err", 32'(err_count), 32'd255);
        f0 = n_fire;
        send_say(32'h0000_0001);
        send_say(32'h0000_0002);
        send_say(32'h0000_0003);
        send_say(32'h0000_0004);
        drain_wait();
        check("b2b_fires", 32'(n_fire - f0), 32'd4);
        check("sat_hold", 32'(err_count), 32'd255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
